// File: rtl/spi_flash_reader_if.sv
// Host-side request/stream bundle of the SPI flash reader (start/addr/len in, bytes and status out).
interface spi_flash_reader_if;
    logic        start;
    logic [23:0] addr;
    logic [15:0] len;
    logic        data_ready;
    logic        busy;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        done;

    // Handshake: start is a one-cycle request taken only while busy=0; data_valid and done are
    // one-cycle strobes; data_ready can hold the stream only when stalling is compiled in.
    modport master (
        output start, addr, len, data_ready,
        input  busy, data_out, data_valid, done
    );
    modport slave (
        input  start, addr, len, data_ready,
        output busy, data_out, data_valid, done
    );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 READ (0x03 + 24-bit address) master that streams len bytes out of a serial flash.
// Optional macro SPI_RD_STALL_EN: data_ready=0 at a byte boundary parks SCK low until it rises.
module spi_flash_reader #(
    parameter int CLK_DIV        = 2,
    parameter int GAP_CYCLES     = 8,
    parameter int DUMMY_BITS     = 1,
    parameter int CS_HIGH_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_flash_reader_if.slave  host,
    output logic               SCK,
    output logic               CSbar,
    output logic               DI,
    input  logic               DO,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_GAP   = 3'd2,
        S_DUMMY = 3'd3,
        S_DATA  = 3'd4,
        S_END   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic [31:0] bit_cnt_q;
    logic [15:0] bytes_left_q;
    logic [31:0] cmd_sr_q;
    logic [7:0]  rx_sr_q;
    logic [7:0]  data_out_q;
    logic        data_valid_q;
    logic        sck_q, cs_q, di_q, busy_q, done_q;
    logic        sck_d, cs_d, di_d, busy_d, done_d;

    logic        tick, shifting, stall, rise, fall, accept, empty_req;
    logic        cmd_last, dummy_last, data_last, gap_last, end_last, byte_last;
    logic [31:0] cmd_word;

    // Phase events; every SCK edge happens on a tick of the CLK_DIV divider.
    always_comb begin
        cmd_word   = {8'h03, host.addr};
        tick       = (cnt_q == 16'(CLK_DIV - 1));
        shifting   = (state_q == S_CMD) || (state_q == S_DUMMY) || (state_q == S_DATA);
        stall      = 1'b0;
`ifdef SPI_RD_STALL_EN
        stall      = (state_q == S_DATA) && !sck_q && (bit_cnt_q[2:0] == 3'd0) &&
                     (bit_cnt_q != 32'd0) && !host.data_ready;
`endif
        rise       = shifting && !sck_q && tick && !stall;
        fall       = shifting && sck_q && tick;
        accept     = (state_q == S_IDLE) && host.start && !busy_q;
        empty_req  = (host.len == 16'd0);
        cmd_last   = (state_q == S_CMD) && fall && (bit_cnt_q == 32'd31);
        dummy_last = (state_q == S_DUMMY) && fall && (bit_cnt_q == 32'(DUMMY_BITS - 1));
        data_last  = (state_q == S_DATA) && fall && (bytes_left_q == 16'd0);
        gap_last   = (state_q == S_GAP) && (cnt_q == 16'(GAP_CYCLES - 1));
        end_last   = (state_q == S_END) && (cnt_q == 16'(CS_HIGH_CYCLES - 1));
        byte_last  = (state_q == S_DATA) && rise && (bit_cnt_q[2:0] == 3'd7);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)     state_d = empty_req ? S_END : S_CMD;
            S_CMD:   if (cmd_last)   state_d = S_GAP;
            S_GAP:   if (gap_last)   state_d = (DUMMY_BITS == 0) ? S_DATA : S_DUMMY;
            S_DUMMY: if (dummy_last) state_d = S_DATA;
            S_DATA:  if (data_last)  state_d = S_END;
            S_END:   if (end_last)   state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Next values of the registered pins and status; DI moves only on SCK falls.
    always_comb begin
        sck_d  = sck_q;
        cs_d   = cs_q;
        di_d   = di_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (accept) begin
            busy_d = 1'b1;
            done_d = empty_req;
            cs_d   = empty_req;
            di_d   = cmd_word[31] & !empty_req;
        end
        if (rise) sck_d = 1'b1;
        if (fall) begin
            sck_d = 1'b0;
            if (state_q == S_CMD) di_d = cmd_last ? 1'b0 : cmd_sr_q[31];
        end
        if (data_last) begin
            cs_d   = 1'b1;
            done_d = 1'b1;
        end
        if (end_last) busy_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= 1'b0;
            cs_q   <= 1'b1;
            di_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sck_q  <= sck_d;
            cs_q   <= cs_d;
            di_q   <= di_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= 16'd0;
            bit_cnt_q    <= 32'd0;
            bytes_left_q <= 16'd0;
            cmd_sr_q     <= 32'd0;
            rx_sr_q      <= 8'd0;
            data_out_q   <= 8'd0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;

            // An empty request skips straight to the last END cycle so busy lasts one cycle.
            if (state_d != state_q)
                cnt_q <= (accept && empty_req) ? 16'(CS_HIGH_CYCLES - 1) : 16'd0;
            else if (stall)
                cnt_q <= cnt_q;
            else if (shifting && tick)
                cnt_q <= 16'd0;
            else if (state_q != S_IDLE)
                cnt_q <= cnt_q + 16'd1;

            if (state_d != state_q)
                bit_cnt_q <= 32'd0;
            else if (((state_q == S_CMD) || (state_q == S_DUMMY)) && fall)
                bit_cnt_q <= bit_cnt_q + 32'd1;
            else if ((state_q == S_DATA) && rise)
                bit_cnt_q <= bit_cnt_q + 32'd1;

            if (accept) begin
                bytes_left_q <= host.len;
                cmd_sr_q     <= {cmd_word[30:0], 1'b0};
            end else begin
                if (byte_last) bytes_left_q <= bytes_left_q - 16'd1;
                if ((state_q == S_CMD) && fall) cmd_sr_q <= {cmd_sr_q[30:0], 1'b0};
            end

            if ((state_q == S_DATA) && rise) rx_sr_q <= {rx_sr_q[6:0], DO};
            if (byte_last) begin
                data_out_q   <= {rx_sr_q[6:0], DO};
                data_valid_q <= 1'b1;
            end
        end
    end

    assign SCK             = sck_q;
    assign CSbar           = cs_q;
    assign DI              = di_q;
    assign host.busy       = busy_q;
    assign host.done       = done_q;
    assign host.data_out   = data_out_q;
    assign host.data_valid = data_valid_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural READ-command flash model.
// Define SPI_RD_STALL_EN for both RTL and bench to include the stall scenario.
module tb_spi_flash_reader;
    localparam int CLK_DIV        = 2;
    localparam int GAP_CYCLES     = 8;
    localparam int DUMMY_BITS     = 1;
    localparam int CS_HIGH_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck, csbar, di;
    logic       do_pin = 1'b0;
    logic [2:0] dbg_state;

    spi_flash_reader_if bus();

    spi_flash_reader #(
        .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES),
        .DUMMY_BITS(DUMMY_BITS), .CS_HIGH_CYCLES(CS_HIGH_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .host(bus),
        .SCK(sck), .CSbar(csbar), .DI(di), .DO(do_pin), .dbg_state(dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // flash model: captures 32 command bits, skips dummy bits, shifts data out on SCK falls
    logic [7:0]  mem [0:255];
    logic [31:0] cap_word;
    int          rise_cnt, total_rises, cs_falls, cs_rises, fk;
    logic [7:0]  fidx;

    always @(negedge csbar) begin
        rise_cnt = 0;
        cap_word = '0;
        do_pin   = 1'b0;
        cs_falls++;
    end
    always @(posedge csbar) cs_rises++;
    always @(posedge sck) if (csbar === 1'b0) begin
        if (rise_cnt < 32) cap_word = {cap_word[30:0], di};
        rise_cnt++;
        total_rises++;
    end
    always @(negedge sck) if (csbar === 1'b0 && rise_cnt >= 32 + DUMMY_BITS) begin
        fk     = rise_cnt - 32 - DUMMY_BITS;
        fidx   = 8'(cap_word[7:0] + 8'(fk / 8));
        do_pin = mem[fidx][7 - (fk % 8)];
    end

    // scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         done_cnt, busy_cycles;

    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) got_q.push_back(bus.data_out);
        if (bus.done === 1'b1) done_cnt++;
        if (bus.busy === 1'b1) busy_cycles++;
    end

    // driver tasks
    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        done_cnt    = 0;
        busy_cycles = 0;
        total_rises = 0;
        cs_falls    = 0;
        cs_rises    = 0;
    endtask

    task automatic start_txn(input logic [23:0] a, input logic [15:0] l);
        @(negedge clk);
        bus.addr  = a;
        bus.len   = l;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (bus.busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.addr = '0; bus.len = '0; bus.data_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (sck !== 1'b0) begin bad++; $display("FAIL reset_sck: got %b want 0", sck); end
        total++; if (csbar !== 1'b1) begin bad++; $display("FAIL reset_csbar: got %b want 1", csbar); end
        total++; if (di !== 1'b0) begin bad++; $display("FAIL reset_di: got %b want 0", di); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h want 00", bus.data_out); end
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL reset_data_valid: got %b want 0", bus.data_valid); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_decode();
        bit to;
        logic [7:0] g, e;
        clear_mon();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        start_txn(24'h000010, 16'd2);
        wait_idle(to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL decode_timeout: got %b want 0", to); end
        total++; if (cap_word !== 32'h03000010) begin bad++; $display("FAIL decode_cmd_word: got %h want 03000010", cap_word); end
        total++; if (total_rises !== 49) begin bad++; $display("FAIL decode_rises: got %0d want 49", total_rises); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL decode_done: got %0d want 1", done_cnt); end
        total++; if (busy_cycles !== 208) begin bad++; $display("FAIL decode_busy_len: got %0d want 208", busy_cycles); end
        total++; if (cs_falls !== 1 || cs_rises !== 1) begin bad++; $display("FAIL decode_cs_edges: got %0d/%0d want 1/1", cs_falls, cs_rises); end
        total++; if (csbar !== 1'b1) begin bad++; $display("FAIL decode_cs_after: got %b want 1", csbar); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL decode_nbytes: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL decode_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_len_zero();
        clear_mon();
        @(negedge clk);
        bus.addr = 24'h123456; bus.len = 16'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL len0_done_pulse: got %b want 1", bus.done); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL len0_busy_high: got %b want 1", bus.busy); end
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL len0_done_end: got %b want 0", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL len0_busy_low: got %b want 0", bus.busy); end
        repeat (8) @(negedge clk);
        total++; if (busy_cycles !== 1) begin bad++; $display("FAIL len0_busy_cycles: got %0d want 1", busy_cycles); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL len0_done_cnt: got %0d want 1", done_cnt); end
        total++; if (total_rises !== 0 || cs_falls !== 0) begin bad++; $display("FAIL len0_no_spi: got rises=%0d cs_falls=%0d want 0/0", total_rises, cs_falls); end
        total++; if (csbar !== 1'b1) begin bad++; $display("FAIL len0_csbar: got %b want 1", csbar); end
    endtask

    task automatic test_ignore_start();
        bit to, seen;
        logic [7:0] g, e;
        clear_mon();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3); exp_q.push_back(8'h69);
        start_txn(24'h000010, 16'd4);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.data_valid === 1'b1) begin seen = 1'b1; break; end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL ignore_first_byte: got %b want 1", seen); end
        repeat (3) @(negedge clk);
        bus.addr = 24'h000040; bus.len = 16'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(to);
        repeat (12) @(negedge clk);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL ignore_timeout: got %b want 0", to); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL ignore_done: got %0d want 1", done_cnt); end
        total++; if (cs_falls !== 1) begin bad++; $display("FAIL ignore_cs_falls: got %0d want 1", cs_falls); end
        total++; if (total_rises !== 65) begin bad++; $display("FAIL ignore_rises: got %0d want 65", total_rises); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL ignore_nbytes: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL ignore_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_reset_mid();
        bit to, seen;
        logic [7:0] g, e;
        clear_mon();
        start_txn(24'h000010, 16'd2);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.data_valid === 1'b1) begin seen = 1'b1; break; end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rstmid_reach_data: got %b want 1", seen); end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (sck !== 1'b0) begin bad++; $display("FAIL rstmid_sck: got %b want 0", sck); end
        total++; if (csbar !== 1'b1) begin bad++; $display("FAIL rstmid_csbar: got %b want 1", csbar); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL rstmid_state: got %0d want 0", dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        exp_q.push_back(8'h3C);
        start_txn(24'h000011, 16'd1);
        wait_idle(to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL rstmid_timeout: got %b want 0", to); end
        total++; if (total_rises !== 41) begin bad++; $display("FAIL rstmid_rises: got %0d want 41", total_rises); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rstmid_nbytes: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL rstmid_byte: got %h want %h", g, e); end
        end
    endtask

`ifdef SPI_RD_STALL_EN
    task automatic test_stall();
        bit to, seen;
        int low_cnt, rises_before;
        logic [7:0] g, e;
        clear_mon();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        start_txn(24'h000010, 16'd2);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.data_valid === 1'b1) begin seen = 1'b1; break; end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL stall_first_byte: got %b want 1", seen); end
        bus.data_ready = 1'b0;
        rises_before = total_rises;
        low_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sck === 1'b0) low_cnt++;
        end
        bus.data_ready = 1'b1;
        // SCK is still in its high phase for the first cycle after the strobe, then parks low.
        total++; if (low_cnt !== 19) begin bad++; $display("FAIL stall_sck_low: got %0d want 19", low_cnt); end
        total++; if (total_rises !== rises_before) begin bad++; $display("FAIL stall_no_rise: got %0d want %0d", total_rises, rises_before); end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL stall_early_done: got %0d want 0", done_cnt); end
        wait_idle(to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL stall_timeout: got %b want 0", to); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
        total++; if (total_rises !== 49) begin bad++; $display("FAIL stall_rises: got %0d want 49", total_rises); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL stall_nbytes: got %0d want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL stall_byte: got %h want %h", g, e); end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[8'h10] = 8'hA5;
        mem[8'h11] = 8'h3C;
        mem[8'h12] = 8'hC3;
        mem[8'h13] = 8'h69;
        test_reset();
        test_decode();
        test_len_zero();
        test_ignore_start();
        test_reset_mid();
`ifdef SPI_RD_STALL_EN
        test_stall();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
